// File: rtl/nandn_pkg.sv
// Shared mode encodings and the per-lane reduction used at the nandn_pipe entry.
package nandn_pkg;

  typedef enum logic [1:0] {
    MODE_NAND = 2'b00,
    MODE_AND  = 2'b01,
    MODE_NOR  = 2'b10,
    MODE_OR   = 2'b11
  } mode_e;

  // Widest lane lane_reduce can evaluate; narrower lanes are zero-padded by the caller.
  localparam int MAX_NIN = 64;

  function automatic logic lane_reduce(input logic [MAX_NIN-1:0] bits,
                                       input int                 n,
                                       input logic [1:0]         mode);
    logic all_ones;
    logic any_one;
    logic result;
    all_ones = 1'b1;
    any_one  = 1'b0;
    for (int i = 0; i < MAX_NIN; i++) begin
      if (i < n) begin
        all_ones = all_ones & bits[i];
        any_one  = any_one | bits[i];
      end
    end
    result = 1'b0;
    case (mode_e'(mode))
      MODE_NAND: result = ~all_ones;
      MODE_AND:  result = all_ones;
      MODE_NOR:  result = ~any_one;
      MODE_OR:   result = any_one;
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/nandn_stage.sv
// One valid/data pipeline register; ready is open when empty or when downstream takes.
module nandn_stage #(
  parameter int W = 1
) (
  input  logic         CK,
  input  logic         CD,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         ready,
  output logic         valid_next
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign ready      = ~valid_reg | down_ready;
  assign valid_next = ready ? up_valid : valid_reg;

  // Data only moves with a valid item so the output keeps the last real result.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (ready) begin
      valid_reg <= up_valid;
      if (up_valid) begin
        data_reg <= up_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/nandn_pipe.sv
// Selectable N-input NAND/AND/NOR/OR on LANES lanes, followed by a STAGES-deep
// valid/ready pipeline with bubble collapsing and a registered occupancy count.
module nandn_pipe #(
  parameter  int NIN    = 2,
  parameter  int LANES  = 1,
  parameter  int STAGES = 2,
  localparam int OCCW   = $clog2(STAGES + 1)
) (
  input  logic                 CK,
  input  logic                 CD,
  input  logic [LANES*NIN-1:0] A,
  input  logic [1:0]           MODE,
  input  logic                 VI,
  output logic                 RI,
  output logic [LANES-1:0]     ZN,
  output logic                 VO,
  input  logic                 RO,
  output logic [OCCW-1:0]      OCC
);

  import nandn_pkg::*;

  logic [LANES-1:0] lane_res;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [MAX_NIN-1:0] padded;
      always_comb begin
        padded          = '0;
        padded[NIN-1:0] = A[gi*NIN +: NIN];
      end
      assign lane_res[gi] = lane_reduce(padded, NIN, MODE);
    end
  endgenerate

  // Index 0 of each chain is the pipe entry; index STAGES is the pipe exit.
  logic             valid_chain [0:STAGES];
  logic [LANES-1:0] data_chain  [0:STAGES];
  logic             ready_chain [0:STAGES];
  logic             valid_next  [0:STAGES-1];

  assign valid_chain[0]      = VI;
  assign data_chain[0]       = lane_res;
  assign ready_chain[STAGES] = RO;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      nandn_stage #(.W(LANES)) u_stage (
        .CK         (CK),
        .CD         (CD),
        .up_valid   (valid_chain[gi]),
        .up_data    (data_chain[gi]),
        .down_ready (ready_chain[gi+1]),
        .valid      (valid_chain[gi+1]),
        .data       (data_chain[gi+1]),
        .ready      (ready_chain[gi]),
        .valid_next (valid_next[gi])
      );
    end
  endgenerate

  assign RI = ready_chain[0];
  assign VO = valid_chain[STAGES];
  assign ZN = data_chain[STAGES];

  // Occupancy is counted from the stages' next valid bits so it lands on the same edge.
  logic [OCCW-1:0] occ_next;
  logic [OCCW-1:0] occ_reg;

  always_comb begin
    occ_next = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_next = occ_next + OCCW'(valid_next[k]);
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign OCC = occ_reg;

endmodule
